// File: rtl/spi_mem_master.sv
// rtl/spi_mem_master.sv - SPI mode-0 master for serial SRAM/flash memories
module spi_mem_master #(
    parameter int ADDR_W         = 24,
    parameter int DATA_BYTES     = 4,
    parameter int CLK_DIV        = 1,
    parameter int READ_DUMMY     = 0,
    parameter int CE_ACTIVE_HIGH = 0
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_req_valid,
    output logic                          o_req_ready,
    input  logic                          i_req_write,
    input  logic [ADDR_W-1:0]             i_req_addr,
    input  logic [$clog2(DATA_BYTES)-1:0] i_req_len,
    input  logic [8*DATA_BYTES-1:0]       i_req_wdata,
    output logic                          o_rsp_valid,
    output logic [8*DATA_BYTES-1:0]       o_rsp_rdata,
    output logic                          o_busy,
    output logic                          o_sclk,
    output logic                          o_ce,
    output logic                          o_si,
    input  logic                          i_so
);
    localparam int DW    = 8 * DATA_BYTES;
    localparam int LEN_W = $clog2(DATA_BYTES);
    localparam int SH_W  = 8 + ADDR_W + READ_DUMMY + DW;
    localparam int CNT_W = $clog2(2 * CLK_DIV);
    localparam int IDX_W = $clog2(DW);
    localparam int PH_W  = 16;
    localparam logic [7:0] CMD_WR = 8'h02;
    localparam logic [7:0] CMD_RD = (READ_DUMMY == 0) ? 8'h03 : 8'h0B;
    localparam logic CE_ON  = (CE_ACTIVE_HIGH != 0);
    localparam logic CE_OFF = ~CE_ON;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DUMMY,
        S_DATA,
        S_DONE
    } state_t;

    state_t            r_state;
    logic              r_write;
    logic [LEN_W-1:0]  r_len;
    logic [SH_W-1:0]   r_shift;
    logic [PH_W-1:0]   r_ph_cnt;
    logic [CNT_W-1:0]  r_div_cnt;
    logic [IDX_W-1:0]  r_rx_idx;
    logic [DW-1:0]     r_rdata;
    logic              r_sclk;
    logic              r_ce;
    logic              r_rsp_valid;

    logic [SH_W-1:0]   w_load_hdr;
    logic [SH_W-1:0]   w_load_dat;
    logic [PH_W-1:0]   w_data_bits;
    logic              w_tick;

    // The whole outgoing frame is one shift register: command and address on
    // top, write data directly below the address, dummy/read slots left zero.
    assign w_load_hdr  = SH_W'({(i_req_write ? CMD_WR : CMD_RD), i_req_addr}) << (READ_DUMMY + DW);
    assign w_load_dat  = i_req_write ? (SH_W'(i_req_wdata) << READ_DUMMY) : '0;
    assign w_data_bits = PH_W'({r_len, 3'b000}) + PH_W'(8);
    assign w_tick      = (r_div_cnt == CNT_W'(CLK_DIV - 1));

    assign o_req_ready = (r_state == S_IDLE);
    assign o_busy      = (r_state != S_IDLE);
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rdata;
    assign o_sclk      = r_sclk;
    assign o_ce        = r_ce;
    assign o_si        = r_shift[SH_W-1];

    // Transfer sequencer: divider, sclk generation, bit shifting and phase control
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_write     <= 1'b0;
            r_len       <= '0;
            r_shift     <= '0;
            r_ph_cnt    <= '0;
            r_div_cnt   <= '0;
            r_rx_idx    <= '0;
            r_rdata     <= '0;
            r_sclk      <= 1'b0;
            r_ce        <= CE_OFF;
            r_rsp_valid <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        r_write   <= i_req_write;
                        r_len     <= i_req_len;
                        r_shift   <= w_load_hdr | w_load_dat;
                        r_ph_cnt  <= PH_W'(8);
                        r_div_cnt <= '0;
                        r_rx_idx  <= IDX_W'(DW - 1);
                        r_rdata   <= '0;
                        r_sclk    <= 1'b0;
                        r_ce      <= CE_ON;
                        r_state   <= S_CMD;
                    end
                end
                S_DONE: begin
                    // ce stays inactive for a full sclk period before the next accept
                    if (r_div_cnt == CNT_W'(2 * CLK_DIV - 1)) begin
                        r_div_cnt <= '0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_div_cnt <= r_div_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    if (w_tick) begin
                        r_div_cnt <= '0;
                        r_sclk    <= ~r_sclk;
                    end else begin
                        r_div_cnt <= r_div_cnt + CNT_W'(1);
                    end
                    // rising sclk: capture read data MSB first
                    if (w_tick && !r_sclk && (r_state == S_DATA) && !r_write) begin
                        r_rdata[r_rx_idx] <= i_so;
                        r_rx_idx          <= r_rx_idx - IDX_W'(1);
                    end
                    // falling sclk: present the next bit and advance phases
                    if (w_tick && r_sclk) begin
                        r_shift <= r_shift << 1;
                        if (r_ph_cnt == PH_W'(1)) begin
                            case (r_state)
                                S_CMD: begin
                                    r_state  <= S_ADDR;
                                    r_ph_cnt <= PH_W'(ADDR_W);
                                end
                                S_ADDR: begin
                                    if (!r_write && (READ_DUMMY > 0)) begin
                                        r_state  <= S_DUMMY;
                                        r_ph_cnt <= PH_W'(READ_DUMMY);
                                    end else begin
                                        r_state  <= S_DATA;
                                        r_ph_cnt <= w_data_bits;
                                    end
                                end
                                S_DUMMY: begin
                                    r_state  <= S_DATA;
                                    r_ph_cnt <= w_data_bits;
                                end
                                default: begin
                                    r_state     <= S_DONE;
                                    r_ce        <= CE_OFF;
                                    r_rsp_valid <= 1'b1;
                                    r_div_cnt   <= '0;
                                    r_shift     <= '0;
                                end
                            endcase
                        end else begin
                            r_ph_cnt <= r_ph_cnt - PH_W'(1);
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spi_mem_master.sv
// tb/tb_spi_mem_master.sv - randomized model-checked bench for spi_mem_master
module tb_spi_mem_master;
    localparam int LIMIT = 3000;

    int AW[3] = '{24, 24, 16};
    int DB[3] = '{4, 4, 2};
    int DV[3] = '{1, 3, 1};
    int RD[3] = '{0, 8, 0};
    bit CEH[3] = '{1'b0, 1'b0, 1'b1};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req_valid;
    logic [2:0]  req_write;
    logic [31:0] req_addr [3];
    logic [2:0]  req_len [3];
    logic [63:0] req_wdata [3];
    logic [2:0]  so;
    wire  [2:0]  req_ready, rsp_valid, busy, sclk, ce, si;
    wire  [31:0] rd0, rd1;
    wire  [15:0] rd2;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    bit          bitq [3][$];
    int          nrise [3] = '{0, 0, 0};
    int          si_bad [3] = '{0, 0, 0};
    int          rise_base [3] = '{0, 0, 0};
    int          si_base [3] = '{0, 0, 0};
    int          hdr_bits [3] = '{0, 0, 0};
    logic [63:0] mem_pat [3];
    logic        prev_sclk [3];
    logic        prev_si [3];

    spi_mem_master #(.ADDR_W(24), .DATA_BYTES(4), .CLK_DIV(1), .READ_DUMMY(0), .CE_ACTIVE_HIGH(0)) dut0 (
        .i_clk(clk), .i_reset(rst), .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]),
        .i_req_write(req_write[0]), .i_req_addr(req_addr[0][23:0]), .i_req_len(req_len[0][1:0]),
        .i_req_wdata(req_wdata[0][31:0]), .o_rsp_valid(rsp_valid[0]), .o_rsp_rdata(rd0),
        .o_busy(busy[0]), .o_sclk(sclk[0]), .o_ce(ce[0]), .o_si(si[0]), .i_so(so[0]));

    spi_mem_master #(.ADDR_W(24), .DATA_BYTES(4), .CLK_DIV(3), .READ_DUMMY(8), .CE_ACTIVE_HIGH(0)) dut1 (
        .i_clk(clk), .i_reset(rst), .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]),
        .i_req_write(req_write[1]), .i_req_addr(req_addr[1][23:0]), .i_req_len(req_len[1][1:0]),
        .i_req_wdata(req_wdata[1][31:0]), .o_rsp_valid(rsp_valid[1]), .o_rsp_rdata(rd1),
        .o_busy(busy[1]), .o_sclk(sclk[1]), .o_ce(ce[1]), .o_si(si[1]), .i_so(so[1]));

    spi_mem_master #(.ADDR_W(16), .DATA_BYTES(2), .CLK_DIV(1), .READ_DUMMY(0), .CE_ACTIVE_HIGH(1)) dut2 (
        .i_clk(clk), .i_reset(rst), .i_req_valid(req_valid[2]), .o_req_ready(req_ready[2]),
        .i_req_write(req_write[2]), .i_req_addr(req_addr[2][15:0]), .i_req_len(req_len[2][0:0]),
        .i_req_wdata(req_wdata[2][15:0]), .o_rsp_valid(rsp_valid[2]), .o_rsp_rdata(rd2),
        .o_busy(busy[2]), .o_sclk(sclk[2]), .o_ce(ce[2]), .o_si(si[2]), .i_so(so[2]));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor and memory model: records si at each sclk rise, drives so while sclk is low
    always @(negedge clk) begin
        int j;
        for (int d = 0; d < 3; d++) begin
            if (sclk[d] === 1'b1 && prev_sclk[d] !== 1'b1) begin
                bitq[d].push_back(si[d]);
                nrise[d] <= nrise[d] + 1;
            end
            if (sclk[d] === 1'b1 && si[d] !== prev_si[d]) si_bad[d] <= si_bad[d] + 1;
            prev_sclk[d] <= sclk[d];
            prev_si[d]   <= si[d];
            j = nrise[d] - rise_base[d] - hdr_bits[d];
            so[d] <= (j >= 0 && j < 64) ? mem_pat[d][63 - j] : 1'($urandom);
        end
    end

    function automatic logic [63:0] get_rdata(input int d);
        case (d)
            0: return 64'(rd0);
            1: return 64'(rd1);
            default: return 64'(rd2);
        endcase
    endfunction

    task automatic present(input int d, input bit wr, input logic [31:0] addr, input int len, input logic [63:0] wdata);
        req_write[d] = wr;
        req_addr[d]  = addr;
        req_len[d]   = 3'(len);
        req_wdata[d] = wdata;
        req_valid[d] = 1'b1;
    endtask

    task automatic scramble(input int d);
        req_write[d] = ~req_write[d];
        req_addr[d]  = $urandom;
        req_len[d]   = 3'($urandom);
        req_wdata[d] = {$urandom, $urandom};
        req_valid[d] = 1'b0;
    endtask

    // Waits for the accept cycle T, arms the memory model, returns in cycle T+1
    task automatic await_accept(input int d, input bit wr, output int t, output logic [63:0] pat);
        int n = 0;
        while (!(req_ready[d] === 1'b1 && req_valid[d] === 1'b1) && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (n >= LIMIT) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout dut%0d: no accept within %0d cycles", d, LIMIT);
        end
        t = cyc;
        pat = {$urandom, $urandom};
        mem_pat[d]   = pat;
        hdr_bits[d]  = 8 + AW[d] + (wr ? 0 : RD[d]);
        rise_base[d] = nrise[d];
        si_base[d]   = si_bad[d];
        bitq[d].delete();
        @(negedge clk);
    endtask

    // Checks one transfer from cycle T+1 until req_ready returns; r is the rsp_valid cycle
    task automatic finish(input int d, input int t, input bit wr, input logic [31:0] addr, input int len,
                          input logic [63:0] wdata, input logic [63:0] pat, input string nm, output int r);
        int n_bits, dw, nbits, cmp_len, bad, k;
        bit expq[$];
        logic [7:0] cmd;
        logic [63:0] exp_rd, got_rd;
        nbits  = 8 * (len + 1);
        n_bits = 8 + AW[d] + (wr ? 0 : RD[d]) + nbits;
        dw     = 8 * DB[d];
        cmd    = wr ? 8'h02 : ((RD[d] == 0) ? 8'h03 : 8'h0B);

        checks++;
        if (ce[d] !== CEH[d] || sclk[d] !== 1'b0 || si[d] !== cmd[7] || busy[d] !== 1'b1 || req_ready[d] !== 1'b0) begin
            failures++;
            $display("FAIL %s start: ce=%b sclk=%b si=%b busy=%b ready=%b, need ce=%b sclk=0 si=%b busy=1 ready=0",
                     nm, ce[d], sclk[d], si[d], busy[d], req_ready[d], CEH[d], cmd[7]);
        end

        k = 0;
        while (rsp_valid[d] !== 1'b1 && k < LIMIT) begin
            @(negedge clk);
            k++;
        end
        r = cyc;
        checks++;
        if (r - t != 2 * n_bits * DV[d] + 1) begin
            failures++;
            $display("FAIL %s rsp_time: got T+%0d, need T+%0d", nm, r - t, 2 * n_bits * DV[d] + 1);
        end
        checks++;
        if (ce[d] !== ~CEH[d] || sclk[d] !== 1'b0) begin
            failures++;
            $display("FAIL %s rsp_pins: ce=%b sclk=%b, need ce=%b sclk=0", nm, ce[d], sclk[d], ~CEH[d]);
        end

        for (int i = 7; i >= 0; i--) expq.push_back(cmd[i]);
        for (int i = AW[d] - 1; i >= 0; i--) expq.push_back(addr[i]);
        if (!wr) for (int i = 0; i < RD[d]; i++) expq.push_back(1'b0);
        cmp_len = expq.size();
        if (wr) begin
            for (int i = dw - 1; i >= dw - nbits; i--) expq.push_back(wdata[i]);
            cmp_len = expq.size();
        end
        checks++;
        if (bitq[d].size() != n_bits) begin
            failures++;
            $display("FAIL %s sclk_count: got %0d rising edges, need %0d", nm, bitq[d].size(), n_bits);
        end
        bad = 0;
        for (int i = 0; i < cmp_len && i < bitq[d].size(); i++)
            if (bitq[d][i] !== expq[i]) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL %s si_stream: %0d of %0d bits differ, need 0", nm, bad, cmp_len);
        end
        checks++;
        if (si_bad[d] != si_base[d]) begin
            failures++;
            $display("FAIL %s si_while_sclk_high: %0d changes, need 0", nm, si_bad[d] - si_base[d]);
        end
        if (!wr) begin
            exp_rd = (pat >> (64 - nbits)) << (dw - nbits);
            got_rd = get_rdata(d);
            checks++;
            if (got_rd !== exp_rd) begin
                failures++;
                $display("FAIL %s rdata: got %h, need %h", nm, got_rd, exp_rd);
            end
        end

        @(negedge clk);
        checks++;
        if (rsp_valid[d] !== 1'b0) begin
            failures++;
            $display("FAIL %s rsp_pulse: rsp_valid=%b one cycle later, need 0", nm, rsp_valid[d]);
        end
        k = 0;
        while (req_ready[d] !== 1'b1 && k < LIMIT) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (cyc - t != 2 * n_bits * DV[d] + 2 * DV[d] + 1) begin
            failures++;
            $display("FAIL %s ready_time: got T+%0d, need T+%0d", nm, cyc - t, 2 * n_bits * DV[d] + 2 * DV[d] + 1);
        end
    endtask

    task automatic xfer(input int d, input bit wr, input logic [31:0] addr, input int len,
                        input logic [63:0] wdata, input logic [15:0] pat_top, input bit force_top, input string nm);
        int t, r;
        logic [63:0] pat;
        present(d, wr, addr, len, wdata);
        await_accept(d, wr, t, pat);
        if (force_top) begin
            pat = {pat_top, pat[47:0]};
            mem_pat[d] = pat;
        end
        scramble(d);
        finish(d, t, wr, addr, len, wdata, pat, nm, r);
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (sclk[d] !== 1'b0 || ce[d] !== ~CEH[d] || si[d] !== 1'b0 || busy[d] !== 1'b0 ||
                rsp_valid[d] !== 1'b0 || get_rdata(d) !== 64'h0 || req_ready[d] !== 1'b1) begin
                failures++;
                $display("FAIL reset dut%0d: sclk=%b ce=%b si=%b busy=%b rsp=%b rdata=%h ready=%b, need 0,%b,0,0,0,0,1",
                         d, sclk[d], ce[d], si[d], busy[d], rsp_valid[d], get_rdata(d), req_ready[d], ~CEH[d]);
            end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_basic();
        xfer(0, 1'b1, 32'h0012_3456, 3, 64'h0000_0000_DEAD_BEEF, 16'h0, 1'b0, "write_basic");
    endtask

    task automatic test_read_basic();
        // memory returns 0xA5 then 0x3C; expected rsp_rdata 0xA53C0000
        xfer(0, 1'b0, $urandom, 1, {$urandom, $urandom}, 16'hA53C, 1'b1, "read_basic");
    endtask

    task automatic test_dummy_read();
        xfer(1, 1'b0, $urandom, 0, {$urandom, $urandom}, 16'h0, 1'b0, "dummy_read_len0");
        xfer(1, 1'b1, $urandom, $urandom_range(0, 3), {$urandom, $urandom}, 16'h0, 1'b0, "div3_write");
    endtask

    task automatic test_ce_high_addr16();
        xfer(2, 1'b1, 32'hFFFF_A55A, 1, {$urandom, $urandom}, 16'h0, 1'b0, "addr16_write");
        xfer(2, 1'b0, $urandom, 1, {$urandom, $urandom}, 16'h0, 1'b0, "addr16_read");
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            int d = $urandom_range(0, 2);
            xfer(d, 1'($urandom), $urandom, $urandom_range(0, DB[d] - 1), {$urandom, $urandom},
                 16'h0, 1'b0, $sformatf("random%0d_dut%0d", i, d));
        end
    endtask

    task automatic test_back_to_back();
        for (int d = 0; d < 2; d++) begin
            bit wa, wb;
            logic [31:0] aa, ab;
            logic [63:0] da, dbw, pa, pb;
            int la, lb, ta, tb, ra, rb;
            wa = 1'($urandom); wb = 1'($urandom);
            aa = $urandom; ab = $urandom;
            da = {$urandom, $urandom}; dbw = {$urandom, $urandom};
            la = $urandom_range(0, DB[d] - 1); lb = $urandom_range(0, DB[d] - 1);
            present(d, wa, aa, la, da);
            await_accept(d, wa, ta, pa);
            present(d, wb, ab, lb, dbw);
            finish(d, ta, wa, aa, la, da, pa, $sformatf("b2b_first_dut%0d", d), ra);
            await_accept(d, wb, tb, pb);
            checks++;
            if (tb - ra != 2 * DV[d]) begin
                failures++;
                $display("FAIL b2b_accept dut%0d: accepted %0d cycles after rsp_valid, need %0d", d, tb - ra, 2 * DV[d]);
            end
            scramble(d);
            finish(d, tb, wb, ab, lb, dbw, pb, $sformatf("b2b_second_dut%0d", d), rb);
        end
    endtask

    task automatic test_reset_mid();
        int t, seen;
        logic [63:0] pat;
        present(0, 1'b1, $urandom, 3, {$urandom, $urandom});
        await_accept(0, 1'b1, t, pat);
        scramble(0);
        repeat (21) @(negedge clk);
        checks++;
        if (sclk[0] !== 1'b1 || ce[0] !== 1'b0) begin
            failures++;
            $display("FAIL midreset_pre: sclk=%b ce=%b, need sclk=1 ce=0", sclk[0], ce[0]);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (ce[0] !== 1'b1 || sclk[0] !== 1'b0 || si[0] !== 1'b0 || busy[0] !== 1'b0 ||
            req_ready[0] !== 1'b1 || rsp_valid[0] !== 1'b0 || rd0 !== 32'h0) begin
            failures++;
            $display("FAIL midreset_async: ce=%b sclk=%b si=%b busy=%b ready=%b rsp=%b rdata=%h, need 1,0,0,0,1,0,0",
                     ce[0], sclk[0], si[0], busy[0], req_ready[0], rsp_valid[0], rd0);
        end
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid[0] !== 1'b0) seen++;
        end
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid[0] !== 1'b0 || busy[0] !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL midreset_no_rsp: %0d cycles with rsp_valid or busy, need 0", seen);
        end
        xfer(0, 1'b0, $urandom, 3, {$urandom, $urandom}, 16'h0, 1'b0, "after_reset_read");
    endtask

    initial begin
        req_valid = '0;
        req_write = '0;
        for (int d = 0; d < 3; d++) begin
            req_addr[d]  = '0;
            req_len[d]   = '0;
            req_wdata[d] = '0;
            mem_pat[d]   = '0;
        end
        test_reset();
        test_write_basic();
        test_read_basic();
        test_dummy_read();
        test_ce_high_addr16();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
